multicycle_core: RTL and testbench
==================================

// Module: multicycle_core
// PURPOSE
//  Parametrised multi-cycle successor of the single-cycle 8-bit datapath. Same 19-bit instruction format.
//  Shared FSM sequences FETCH/DECODE/EXEC/MEM/WB over one ALU; instruction and data memories sit behind
//  req/ack handshakes so wait-state memories stall the core cleanly. Registered Z/C flags, HALT, retire counter.
// PARAMETERS
//  DATA_W    8      datapath/register width (>=8); imm8 sign-extended to DATA_W
//  PC_W      12     PC / instruction address width (>=12); imm8 offset sign-extended to PC_W
//  NREGS     8      register count, power of 2, <=8 (3-bit fields index it)
//  RESET_PC  0      PC value loaded on reset
//  CNT_W     32     retired-instruction counter width
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous reset, active-high
//  imem_req     out  1       instruction fetch request
//  imem_addr    out  PC_W    fetch address (=pc)
//  imem_ack     in   1       fetch done; imem_rdata valid this cycle
//  imem_rdata   in   19      instruction word
//  dmem_req     out  1       data access request
//  dmem_we      out  1       1=store, 0=load
//  dmem_addr    out  DATA_W  effective address R[rs]+sext(imm8)
//  dmem_wdata   out  DATA_W  store data R[rd]
//  dmem_ack     in   1       access done; dmem_rdata valid this cycle (loads)
//  dmem_rdata   in   DATA_W  load data
//  halted       out  1       core in HALT state
//  retired      out  CNT_W   instructions completed since reset (saturates at all-ones)
// BEHAVIOUR
//  Encoding: cls=ir[18:17], op=ir[16:14], rd=ir[13:11], rs=ir[10:8], rt=ir[7:5], imm8=ir[7:0], tgt=ir[11:0].
//  cls 00 R-ALU rd<=rs op rt; 01 I-ALU rd<=rs op sext(imm8); 10 op000 LW rd<=M[ea], op001 SW M[ea]<=rd;
//  cls 11 op000 JMP pc<=zext/trunc(tgt); 001 BZ,010 BNZ,011 BC,100 BNC pc<=pc+1+sext(imm8) if taken; 111 HALT.
//  Undefined op (cls10 op>=010, cls11 op 101/110): NOP, retires.
//  ALU op: 000 ADD,001 ADC(+C),010 SUB,011 SBB(-C),100 AND,101 OR,110 XOR,111 SHL1 (C<=msb out).
//  Flags: only cls 00/01 update Z (result==0) and C (carry out; SUB/SBB C=borrow; logic ops C<=0).
//  R0 reads as 0, writes to R0 dropped. Widths: all arithmetic mod 2^DATA_W / 2^PC_W, PC wraps.
//  FSM: FETCH: imem_req=1 until imem_ack; on ack ir<=rdata, pc<=pc+1 -> DECODE.
//   DECODE: latch A=R[rs], B=R[rt or rd] -> EXEC.
//   EXEC: ALU/ea/branch calc; cls00/01 -> WB; cls10 -> MEM; JMP/branch/NOP update pc, retire -> FETCH;
//    HALT -> HALT.
//   MEM: dmem_req=1, addr/wdata/we stable until dmem_ack; on ack: SW retire -> FETCH, LW mdr<=rdata -> WB.
//   WB: write rd, update flags (ALU only), retire -> FETCH. HALT: absorbing until rst.
//  Latency w/ zero-wait (ack same cycle as req): ALU 4, LW 5, SW 4, branch/jump 3 cycles.
//  Combinational ack (same cycle as req) legal; ack while req=0 ignored. req never drops before ack.
//  retired increments exactly once per completed instruction, in the cycle entering FETCH; HALT not counted.
//  Reset (any time, incl. mid-handshake): state FETCH, pc=RESET_PC, regs/ir/A/B/mdr/Z/C=0, retired=0,
//   halted=0; imem_req/dmem_req deassert asynchronously; late ack after reset deassert only honoured
//   if request is outstanding (first FETCH). Memory must not retain pending transaction across reset.
//  Reset values: imem_req=0 while rst high, 1 in first cycle after; dmem_req=dmem_we=0; addr/wdata=0.
// STRUCTURE
//  core_pkg: state_t enum {S_FETCH,S_DECODE,S_EXEC,S_MEM,S_WB,S_HALT}; CLS_*/OP_*/ALU_* localparams;
//   field-extract functions.
//  Sub-module alu_core #(DATA_W): a, b, cin, op -> y, cout, z (combinational).
//  Register file, FSM, PC logic inline.
// TESTING
//  1 Reset, zero-wait mem: ADDI R1,R0,5; ADDI R2,R0,-3; ADD R3,R1,R2 -> R3=2, Z=0, C=1, retired=3 @ cycle 12.
//  2 SUB R4,R1,R1 -> R4=0, Z=1; BZ +2 taken -> pc=old+3; BNZ not taken -> pc+1; 3 cycles each.
//  3 Wait states: imem ack after 3 cycles, dmem after 2; SW R1,[R0+0x10] then LW R5 -> R5=5,
//    addr/data stable throughout req.
//  4 ADDI R0,R0,7 then ADD R6,R0,R0 -> R6=0; JMP 0xFFF; PC_W=12 wrap: pc+1 -> 0x000.
//  5 Assert rst mid-MEM with dmem_req high -> req low same cycle, pc=RESET_PC, retired=0, refetch.
//  6 HALT -> halted=1, no further imem_req; DATA_W=16 variant: ADDI -1 sign-extends to 0xFFFF.

Source files
------------

// File: rtl/multicycle_core_pkg.sv
// Shared types, field encodings and instruction field extractors for the multi-cycle core.
package multicycle_core_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam int IR_W = 19;

  localparam logic [1:0] CLS_R   = 2'b00;
  localparam logic [1:0] CLS_I   = 2'b01;
  localparam logic [1:0] CLS_MEM = 2'b10;
  localparam logic [1:0] CLS_CTL = 2'b11;

  localparam logic [2:0] OP_LW   = 3'b000;
  localparam logic [2:0] OP_SW   = 3'b001;
  localparam logic [2:0] OP_JMP  = 3'b000;
  localparam logic [2:0] OP_BZ   = 3'b001;
  localparam logic [2:0] OP_BNZ  = 3'b010;
  localparam logic [2:0] OP_BC   = 3'b011;
  localparam logic [2:0] OP_BNC  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_ADC = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_SBB = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_SHL = 3'b111;

  function automatic logic [1:0] f_cls(input logic [IR_W-1:0] ir);
    return ir[18:17];
  endfunction

  function automatic logic [2:0] f_op(input logic [IR_W-1:0] ir);
    return ir[16:14];
  endfunction

  function automatic logic [2:0] f_rd(input logic [IR_W-1:0] ir);
    return ir[13:11];
  endfunction

  function automatic logic [2:0] f_rs(input logic [IR_W-1:0] ir);
    return ir[10:8];
  endfunction

  function automatic logic [2:0] f_rt(input logic [IR_W-1:0] ir);
    return ir[7:5];
  endfunction

  function automatic logic [7:0] f_imm8(input logic [IR_W-1:0] ir);
    return ir[7:0];
  endfunction

  function automatic logic [11:0] f_tgt(input logic [IR_W-1:0] ir);
    return ir[11:0];
  endfunction

endpackage

// File: rtl/multicycle_core_alu.sv
// Combinational ALU shared by arithmetic, logic and effective-address computation.
module alu_core
  import multicycle_core_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] y,
  output logic              cout,
  output logic              z
);

  logic [DATA_W:0] ext;
  logic [DATA_W:0] cin_ext;

  assign cin_ext = {{DATA_W{1'b0}}, cin};

  // The extra top bit carries out of additions and goes high on borrow for subtractions.
  always_comb begin
    ext = '0;
    case (op)
      ALU_ADD: ext = {1'b0, a} + {1'b0, b};
      ALU_ADC: ext = {1'b0, a} + {1'b0, b} + cin_ext;
      ALU_SUB: ext = {1'b0, a} - {1'b0, b};
      ALU_SBB: ext = {1'b0, a} - {1'b0, b} - cin_ext;
      ALU_AND: ext = {1'b0, a & b};
      ALU_OR:  ext = {1'b0, a | b};
      ALU_XOR: ext = {1'b0, a ^ b};
      ALU_SHL: ext = {a, 1'b0};
      default: ext = '0;
    endcase
  end

  assign y    = ext[DATA_W-1:0];
  assign cout = ext[DATA_W];
  assign z    = (y == '0);

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle core: FETCH/DECODE/EXEC/MEM/WB sequencing over one ALU with req/ack memories.
// Handshake: a request stays high with stable address/data until the cycle its ack is seen; ack without request is ignored.
module multicycle_core
  import multicycle_core_pkg::*;
#(
  parameter int              DATA_W   = 8,
  parameter int              PC_W     = 12,
  parameter int              NREGS    = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [IR_W-1:0]   imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  localparam int RA_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  state_t              state;
  logic [PC_W-1:0]     pc;
  logic [IR_W-1:0]     ir;
  logic [DATA_W-1:0]   a_q, b_q, mdr, ea_q;
  logic                z_q, c_q;
  logic [DATA_W-1:0]   regs [NREGS];

  logic [1:0]          cls;
  logic [2:0]          op, rd, rs, rt;
  logic [RA_W-1:0]     rd_a, rs_a, rt_a;
  logic signed [7:0]   imm_s;
  logic [DATA_W-1:0]   imm_d;
  logic [PC_W-1:0]     imm_p, tgt_p;
  logic [DATA_W-1:0]   rs_val, rt_val, rd_val;
  logic [DATA_W-1:0]   alu_b, alu_y;
  logic [2:0]          alu_op;
  logic                alu_c, alu_z;
  logic                mem_op, taken, retire;

  assign cls   = f_cls(ir);
  assign op    = f_op(ir);
  assign rd    = f_rd(ir);
  assign rs    = f_rs(ir);
  assign rt    = f_rt(ir);
  assign rd_a  = rd[RA_W-1:0];
  assign rs_a  = rs[RA_W-1:0];
  assign rt_a  = rt[RA_W-1:0];
  assign imm_s = f_imm8(ir);
  assign imm_d = DATA_W'(imm_s);
  assign imm_p = PC_W'(imm_s);
  assign tgt_p = PC_W'(f_tgt(ir));

  always_comb begin
    rs_val = (rs_a == '0) ? '0 : regs[rs_a];
    rt_val = (rt_a == '0) ? '0 : regs[rt_a];
    rd_val = (rd_a == '0) ? '0 : regs[rd_a];
  end

  // Memory ops borrow the ALU as an adder for R[rs]+sext(imm8).
  assign alu_op = cls[1] ? ALU_ADD : op;
  assign alu_b  = (cls == CLS_R) ? b_q : imm_d;

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .a    (a_q),
    .b    (alu_b),
    .cin  (c_q),
    .op   (alu_op),
    .y    (alu_y),
    .cout (alu_c),
    .z    (alu_z)
  );

  assign mem_op = (op == OP_LW) || (op == OP_SW);

  always_comb begin
    taken = 1'b0;
    case (op)
      OP_JMP:  taken = 1'b1;
      OP_BZ:   taken = z_q;
      OP_BNZ:  taken = !z_q;
      OP_BC:   taken = c_q;
      OP_BNC:  taken = !c_q;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    retire = 1'b0;
    case (state)
      S_EXEC:  retire = (cls == CLS_MEM && !mem_op) || (cls == CLS_CTL && op != OP_HALT);
      S_MEM:   retire = dmem_ack && (op == OP_SW);
      S_WB:    retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  // Requests are gated by rst so they drop the moment reset asserts.
  assign imem_req   = (state == S_FETCH) && !rst;
  assign imem_addr  = pc;
  assign dmem_req   = (state == S_MEM) && !rst;
  assign dmem_we    = dmem_req && (op == OP_SW);
  assign dmem_addr  = ea_q;
  assign dmem_wdata = b_q;
  assign halted     = (state == S_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      mdr   <= '0;
      ea_q  <= '0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            ir    <= imem_rdata;
            pc    <= pc + PC_W'(1);
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q   <= rs_val;
          b_q   <= (cls == CLS_R) ? rt_val : rd_val;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (!cls[1]) begin
            state <= S_WB;
          end else if (cls == CLS_MEM) begin
            if (mem_op) begin
              ea_q  <= alu_y;
              state <= S_MEM;
            end else begin
              state <= S_FETCH;
            end
          end else if (op == OP_HALT) begin
            state <= S_HALT;
          end else begin
            // pc already points past this instruction, so branch targets are pc+1+offset.
            if (taken) pc <= (op == OP_JMP) ? tgt_p : pc + imm_p;
            state <= S_FETCH;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (op == OP_SW) begin
              state <= S_FETCH;
            end else begin
              mdr   <= dmem_rdata;
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          if (rd_a != '0) regs[rd_a] <= cls[1] ? mdr : alu_y;
          if (!cls[1]) begin
            z_q <= alu_z;
            c_q <= alu_c;
          end
          state <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired <= '0;
    end else if (retire && (retired != '1)) begin
      retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: ISA-level reference model feeds expected fetch/data transactions to a scoreboard.
module tb_multicycle_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack;
  logic [11:0] imem_addr;
  logic [18:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic        halted;
  logic [31:0] retired;

  logic        imem16_req, dmem16_req, dmem16_we, halted16;
  logic [11:0] imem16_addr;
  logic [18:0] imem16_rdata;
  logic [15:0] dmem16_addr, dmem16_wdata;
  logic [31:0] retired16;
  logic [15:0] st16_addr = '0;
  logic [15:0] st16_data = '0;

  logic [18:0] imem [4096];
  logic [7:0]  dmem [256];
  logic [47:0] exp_fetch_q[$];
  logic [16:0] exp_dmem_q[$];
  int          exp_ret_final;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_fc = 0;
  bit          zero_wait = 1'b1;
  bit          d_busy = 1'b0;
  logic [7:0]  d_addr0, d_data0;
  logic [1:0]  i_cnt, d_cnt;
  logic        noise;

  localparam logic [18:0] HALT_W = {2'b11, 3'd7, 14'd0};

  multicycle_core dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .halted(halted), .retired(retired)
  );

  multicycle_core #(.DATA_W(16)) dut16 (
    .clk(clk), .rst(rst),
    .imem_req(imem16_req), .imem_addr(imem16_addr), .imem_ack(imem16_req), .imem_rdata(imem16_rdata),
    .dmem_req(dmem16_req), .dmem_we(dmem16_we), .dmem_addr(dmem16_addr), .dmem_wdata(dmem16_wdata),
    .dmem_ack(dmem16_req), .dmem_rdata(16'h0000), .halted(halted16), .retired(retired16)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] enc(input logic [1:0] cl, input logic [2:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs, input logic [7:0] low);
    return {cl, op, rd, rs, low};
  endfunction

  function automatic logic [1:0] pick_wait();
    return zero_wait ? 2'd0 : 2'($urandom_range(0, 3));
  endfunction

  function automatic logic [18:0] prog16(input logic [11:0] a);
    case (a)
      12'd0:   return enc(2'd1, 3'd0, 3'd1, 3'd0, 8'hFF);
      12'd1:   return enc(2'd2, 3'd1, 3'd1, 3'd0, 8'h04);
      default: return HALT_W;
    endcase
  endfunction

  // ---------------- memory responders ----------------
  assign imem_rdata   = imem[imem_addr];
  assign dmem_rdata   = dmem[dmem_addr];
  assign imem_ack     = imem_req ? (i_cnt == 2'd0) : noise;
  assign dmem_ack     = dmem_req ? (d_cnt == 2'd0) : noise;
  assign imem16_rdata = prog16(imem16_addr);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      i_cnt <= 2'd0;
      d_cnt <= 2'd0;
      noise <= 1'b0;
    end else begin
      noise <= 1'($urandom_range(0, 1));
      if (imem_req) i_cnt <= (i_cnt == 2'd0) ? pick_wait() : i_cnt - 2'd1;
      if (dmem_req) begin
        if (d_cnt == 2'd0) begin
          d_cnt <= pick_wait();
          if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
        end else begin
          d_cnt <= d_cnt - 2'd1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && dmem16_req && dmem16_we) begin
      st16_addr <= dmem16_addr;
      st16_data <= dmem16_wdata;
    end
  end

  // ---------------- reference model ----------------
  // Executes the program at ISA level and queues every expected fetch and data access.
  task automatic run_model();
    logic [11:0] pc;
    logic [7:0]  r [8];
    logic [7:0]  md [256];
    logic        z, c, tk;
    int          lat, ret, a, b, s, y, simm, ea;
    logic [18:0] w;
    logic [1:0]  cl;
    logic [2:0]  op, rd, rs, rt;
    logic [7:0]  im;
    exp_fetch_q.delete();
    exp_dmem_q.delete();
    for (int i = 0; i < 8; i++) r[i] = 8'h00;
    for (int i = 0; i < 256; i++) md[i] = dmem[i];
    pc = 12'd0; z = 1'b0; c = 1'b0; lat = 0; ret = 0; exp_ret_final = -1;
    for (int step = 0; step < 2000; step++) begin
      exp_fetch_q.push_back({pc, 4'(lat), 32'(ret)});
      w = imem[pc];
      pc = pc + 12'd1;
      cl = w[18:17]; op = w[16:14]; rd = w[13:11]; rs = w[10:8]; rt = w[7:5]; im = w[7:0];
      simm = (im >= 8'd128) ? int'(im) - 256 : int'(im);
      lat = 3;
      if (cl == 2'd3 && op == 3'd7) begin
        exp_ret_final = ret;
        break;
      end
      ret++;
      if (cl <= 2'd1) begin
        a = int'(r[rs]);
        b = (cl == 2'd0) ? int'(r[rt]) : int'(im);
        case (op)
          3'd0:    s = a + b;
          3'd1:    s = a + b + int'(c);
          3'd2:    s = a - b;
          3'd3:    s = a - b - int'(c);
          3'd4:    s = a & b;
          3'd5:    s = a | b;
          3'd6:    s = a ^ b;
          default: s = a * 2;
        endcase
        y = s & 255;
        if (op <= 3'd1 || op == 3'd7) c = (s > 255);
        else if (op <= 3'd3)          c = (s < 0);
        else                          c = 1'b0;
        z = (y == 0);
        if (rd != 3'd0) r[rd] = 8'(y);
        lat = 4;
      end else if (cl == 2'd2) begin
        ea = (int'(r[rs]) + simm) & 255;
        if (op == 3'd0) begin
          exp_dmem_q.push_back({1'b0, 8'(ea), 8'h00});
          if (rd != 3'd0) r[rd] = md[ea];
          lat = 5;
        end else if (op == 3'd1) begin
          exp_dmem_q.push_back({1'b1, 8'(ea), r[rd]});
          md[ea] = r[rd];
          lat = 4;
        end
      end else begin
        case (op)
          3'd0:    tk = 1'b1;
          3'd1:    tk = z;
          3'd2:    tk = !z;
          3'd3:    tk = c;
          3'd4:    tk = !c;
          default: tk = 1'b0;
        endcase
        if (tk) pc = (op == 3'd0) ? w[11:0] : 12'((int'(pc) + simm) & 4095);
      end
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [47:0] fe;
    logic [16:0] de;
    if (rst) begin
      d_busy = 1'b0;
    end else begin
      if (imem_req && imem_ack) begin
        if (exp_fetch_q.size() == 0) begin
          chk("fetch_unexpected", {52'd0, imem_addr}, 64'hFFFF_FFFF);
        end else begin
          fe = exp_fetch_q.pop_front();
          chk("fetch_pc", imem_addr, fe[47:36]);
          chk("retired_at_fetch", retired, fe[31:0]);
          if (zero_wait && fe[35:32] != 4'd0) chk("latency", cyc - last_fc, fe[35:32]);
        end
        last_fc = cyc;
      end
      if (dmem_req && !d_busy) begin
        d_busy  = 1'b1;
        d_addr0 = dmem_addr;
        d_data0 = dmem_wdata;
      end
      if (dmem_req && dmem_ack) begin
        chk("dmem_addr_stable", dmem_addr, d_addr0);
        chk("dmem_wdata_stable", dmem_wdata, d_data0);
        d_busy = 1'b0;
        if (exp_dmem_q.size() == 0) begin
          chk("dmem_unexpected", {55'd0, dmem_we, dmem_addr}, 64'hFFFF_FFFF);
        end else begin
          de = exp_dmem_q.pop_front();
          chk("dmem_we", dmem_we, de[16]);
          chk("dmem_addr", dmem_addr, de[15:8]);
          if (de[16]) chk("dmem_wdata", dmem_wdata, de[7:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_p1();
    for (int i = 0; i < 4096; i++) imem[i] = HALT_W;
    imem[0]     = enc(2'd3, 3'd3, 3'd0, 3'd0, 8'd20);      // BC +20
    imem[1]     = enc(2'd1, 3'd0, 3'd1, 3'd0, 8'd5);       // ADDI R1,R0,5
    imem[2]     = enc(2'd1, 3'd0, 3'd2, 3'd0, 8'hFD);      // ADDI R2,R0,-3
    imem[3]     = enc(2'd0, 3'd0, 3'd3, 3'd1, {3'd2, 5'd0}); // ADD R3,R1,R2
    imem[4]     = enc(2'd2, 3'd1, 3'd3, 3'd0, 8'h20);      // SW R3,[R0+0x20]
    imem[5]     = enc(2'd0, 3'd2, 3'd4, 3'd1, {3'd1, 5'd0}); // SUB R4,R1,R1
    imem[6]     = enc(2'd3, 3'd1, 3'd0, 3'd0, 8'd2);       // BZ +2
    imem[9]     = enc(2'd3, 3'd2, 3'd0, 3'd0, 8'd5);       // BNZ +5
    imem[10]    = enc(2'd1, 3'd0, 3'd0, 3'd0, 8'd7);       // ADDI R0,R0,7
    imem[11]    = enc(2'd0, 3'd0, 3'd6, 3'd0, 8'd0);       // ADD R6,R0,R0
    imem[12]    = enc(2'd2, 3'd1, 3'd6, 3'd0, 8'h21);
    imem[13]    = enc(2'd2, 3'd1, 3'd4, 3'd0, 8'h22);
    imem[14]    = enc(2'd2, 3'd0, 3'd5, 3'd0, 8'h20);      // LW R5,[R0+0x20]
    imem[15]    = enc(2'd2, 3'd1, 3'd5, 3'd5, 8'h10);      // SW R5,[R5+0x10]
    imem[16]    = enc(2'd0, 3'd0, 3'd3, 3'd1, {3'd2, 5'd0});
    imem[17]    = {2'b11, 3'd0, 2'b00, 12'hFFF};           // JMP 0xFFF
    imem[12'hFFF] = enc(2'd2, 3'd1, 3'd1, 3'd0, 8'h23);    // then pc wraps to 0
    imem[21]    = enc(2'd2, 3'd3, 3'd0, 3'd0, 8'd0);       // undefined -> NOP
    imem[22]    = enc(2'd3, 3'd5, 3'd0, 3'd0, 8'd0);       // undefined -> NOP
  endtask

  task automatic gen_random();
    int k, n;
    n = 30;
    for (int i = 0; i < 4096; i++) imem[i] = HALT_W;
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2: imem[i] = enc(2'd0, 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom));
        3, 4:    imem[i] = enc(2'd1, 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom));
        5:       imem[i] = enc(2'd2, 3'd1, 3'($urandom), 3'($urandom), 8'($urandom));
        6:       imem[i] = enc(2'd2, 3'd0, 3'($urandom), 3'($urandom), 8'($urandom));
        7, 8:    imem[i] = enc(2'd3, 3'($urandom_range(1, 4)), 3'd0, 3'd0, 8'($urandom_range(0, 4)));
        default: imem[i] = ($urandom_range(0, 1) == 0) ? enc(2'd2, 3'($urandom_range(2, 7)), 3'd0, 3'd0, 8'd0)
                                                       : enc(2'd3, 3'($urandom_range(5, 6)), 3'd0, 3'd0, 8'd0);
      endcase
    end
  endtask

  task automatic init_dmem();
    for (int i = 0; i < 256; i++) dmem[i] = 8'($urandom);
  endtask

  task automatic start_run(input bit zw);
    rst = 1'b1;
    zero_wait = zw;
    run_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("post_rst_imem_req", imem_req, 1'b1);
    chk("post_rst_pc", imem_addr, 12'd0);
  endtask

  task automatic finish_run();
    int i, hi;
    i = 0;
    while (!halted && i < 4000) begin
      @(posedge clk);
      i++;
    end
    if (!halted) begin
      n_cmp++;
      n_bad++;
      $display("FAIL halt_timeout: halted=0 after 4000 cycles, expected 1");
    end
    hi = 0;
    repeat (4) begin
      @(negedge clk);
      if (imem_req) hi++;
    end
    chk("halt_no_fetch", hi, 0);
    chk("halted", halted, 1'b1);
    chk("retired_final", retired, exp_ret_final);
    chk("fetch_q_drained", exp_fetch_q.size(), 0);
    chk("dmem_q_drained", exp_dmem_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit seen;
    #3;
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_dmem_req", dmem_req, 1'b0);
    chk("rst_dmem_we", dmem_we, 1'b0);
    chk("rst_dmem_addr", dmem_addr, 8'h00);
    chk("rst_dmem_wdata", dmem_wdata, 8'h00);
    chk("rst_halted", halted, 1'b0);
    chk("rst_retired", retired, 0);

    load_p1();
    init_dmem();
    start_run(1'b1);
    finish_run();
    chk("w16_store_addr", st16_addr, 16'h0004);
    chk("w16_store_data", st16_data, 16'hFFFF);
    chk("w16_halted", halted16, 1'b1);

    load_p1();
    init_dmem();
    start_run(1'b0);
    finish_run();

    // Reset asserted while a data access is outstanding.
    load_p1();
    init_dmem();
    start_run(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (dmem_req) seen = 1'b1;
    end
    chk("mem_reached", seen, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("midmem_dmem_req", dmem_req, 1'b0);
    chk("midmem_imem_req", imem_req, 1'b0);
    chk("midmem_retired", retired, 0);
    chk("midmem_pc", imem_addr, 12'd0);
    chk("midmem_dmem_addr", dmem_addr, 8'h00);
    start_run(1'b0);
    finish_run();

    for (int t = 0; t < 6; t++) begin
      gen_random();
      init_dmem();
      start_run(t % 2 == 0);
      finish_run();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
